// File: rtl/uart_receiver_fsm.sv
// ---------------------------------------------------------------------------
// uart_receiver_fsm
//
// Oversampling UART receiver. The asynchronous line is synchronized, a start
// bit is qualified by a 2-of-3 majority vote around mid-bit (which rejects short
// glitches), and DATA_WIDTH data bits are recovered LSB first. An optional
// parity bit follows the data, and then the stop bit. Each completed frame
// gives exactly one single-cycle result: either data_valid with a new word on
// parallel_data, or one or both of the error flags.
//
// Ports
//   clk            oversampling clock, `prescale` cycles per bit
//   reset          asynchronous, active-low
//   serial_in      UART line (idles high), asynchronous to clk
//   parity_enable  frame carries a parity bit after the data
//   parity_type    0 = even, 1 = odd
//   prescale       clk cycles per bit (even, >= 8)
//   parallel_data  last correctly received word
//   data_valid     one-cycle pulse: parallel_data was just updated
//   parity_error   one-cycle pulse: parity bit mismatch
//   stop_error     one-cycle pulse: stop bit sampled low
//   busy           a frame is in progress (FSM not idle)
// ---------------------------------------------------------------------------
module uart_receiver_fsm #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      serial_in,
    input  logic                      parity_enable,
    input  logic                      parity_type,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [DATA_WIDTH-1:0]     parallel_data,
    output logic                      data_valid,
    output logic                      parity_error,
    output logic                      stop_error,
    output logic                      busy
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0]             BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] P_ONE    = PRESCALE_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state, state_nxt;

    // -----------------------------------------------------------------------
    // Line synchronizer. Resets to the idle (high) level so that a reset
    // release does not look like a start edge unless the line really is low.
    // -----------------------------------------------------------------------
    logic sync_meta;
    logic rx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b1;
            rx        <= 1'b1;
        end else begin
            sync_meta <= serial_in;
            rx        <= sync_meta;
        end
    end

    // -----------------------------------------------------------------------
    // Frame configuration, frozen for the whole frame at IDLE->START.
    // -----------------------------------------------------------------------
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic                      parity_en_q;
    logic                      parity_type_q;

    // -----------------------------------------------------------------------
    // Bit timing. edge_cnt runs 0..prescale-1 inside every bit. The three
    // samples sit around mid-bit; the vote is taken on the third one.
    // -----------------------------------------------------------------------
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [PRESCALE_WIDTH-1:0] half;
    logic                      at_s0;
    logic                      at_s1;
    logic                      at_dec;
    logic                      at_end;

    assign half   = prescale_q >> 1;
    assign at_s0  = (edge_cnt == half - P_ONE);
    assign at_s1  = (edge_cnt == half);
    assign at_dec = (edge_cnt == half + P_ONE);
    assign at_end = (edge_cnt == prescale_q - P_ONE);

    logic s0;
    logic s1;
    logic maj;

    // The third sample is the live rx value at the decision point.
    assign maj = (s0 & s1) | (s0 & rx) | (s1 & rx);

    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  parity_bit;

    // Control strobes from the next-state logic.
    logic start_frame;
    logic shift_en;
    logic bit_adv;
    logic par_store;
    logic frame_done;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // -----------------------------------------------------------------------
    // FSM next state and control strobes
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        bit_adv     = 1'b0;
        par_store   = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx) begin
                    state_nxt   = START;
                    start_frame = 1'b1;
                end
            end
            START: begin
                // A start bit that votes high was a glitch: drop it silently.
                if (at_dec && maj)  state_nxt = IDLE;
                else if (at_end)    state_nxt = DATA;
            end
            DATA: begin
                if (at_dec) shift_en = 1'b1;
                if (at_end) begin
                    if (bit_cnt == BIT_LAST)
                        state_nxt = parity_en_q ? PARITY : STOP;
                    else
                        bit_adv = 1'b1;
                end
            end
            PARITY: begin
                if (at_dec) par_store = 1'b1;
                if (at_end) state_nxt = STOP;
            end
            STOP: begin
                // Leave at mid stop bit so a slightly fast transmitter, or a
                // back-to-back start bit, is never missed.
                if (at_dec) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Configuration capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale_q    <= '0;
            parity_en_q   <= 1'b0;
            parity_type_q <= 1'b0;
        end else if (start_frame) begin
            prescale_q    <= prescale;
            parity_en_q   <= parity_enable;
            parity_type_q <= parity_type;
        end
    end

    // -----------------------------------------------------------------------
    // Edge and bit counters. edge_cnt is held at 0 in IDLE so that the first
    // START cycle starts counting from 0.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_cnt <= '0;
        end else if (state == IDLE || state_nxt == IDLE || at_end) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + P_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
        end else if (state != DATA) begin
            bit_cnt <= '0;
        end else if (bit_adv) begin
            bit_cnt <= bit_cnt + BW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Sampling, shift register and parity bit
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else begin
            if (at_s0) s0 <= rx;
            if (at_s1) s1 <= rx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            // LSB first: after DATA_WIDTH shifts bit 0 of the frame is bit 0.
            if (shift_en)  shift_reg  <= {maj, shift_reg[DATA_WIDTH-1:1]};
            if (par_store) parity_bit <= maj;
        end
    end

    // -----------------------------------------------------------------------
    // Frame evaluation. The stop bit is the live vote at the STOP decision
    // point; results are registered, giving single-cycle pulses.
    // -----------------------------------------------------------------------
    logic stop_bad;
    logic par_bad;

    assign stop_bad = ~maj;
    assign par_bad  = parity_en_q & (parity_bit != ((^shift_reg) ^ parity_type_q));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parallel_data <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            stop_error    <= 1'b0;
        end else begin
            data_valid   <= frame_done & ~stop_bad & ~par_bad;
            parity_error <= frame_done & par_bad;
            stop_error   <= frame_done & stop_bad;
            if (frame_done & ~stop_bad & ~par_bad)
                parallel_data <= shift_reg;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/uart_receiver_fsm.md
# uart_receiver_fsm

Serial-to-parallel UART receiver and the receive-side counterpart of the team's UART transmitter. It samples the asynchronous `serial_in` line with an oversampling clock and detects the start bit with glitch rejection. It recovers DATA_WIDTH data bits LSB first, then optionally checks a parity bit and checks the stop bit. It presents the byte to the downstream system logic with a one-cycle valid pulse and one-cycle error flags.

## Interface
- DATA_WIDTH, 8, number of data bits per frame
- PRESCALE_WIDTH, 6, width of the `prescale` input
- clk  input  1  oversampling clock (`prescale` cycles per bit)
- reset  input  1  asynchronous, active-low reset
- serial_in  input  1  UART line, asynchronous to clk; idles high
- parity_enable  input  1  1 = frame carries a parity bit after the data
- parity_type  input  1  0 = even, 1 = odd
- prescale  input  PRESCALE_WIDTH  clk cycles per bit; legal values are even and >= 8
- parallel_data  output  DATA_WIDTH  last correctly received word
- data_valid  output  1  one-cycle pulse: new word on `parallel_data`
- parity_error  output  1  one-cycle pulse: parity mismatch
- stop_error  output  1  one-cycle pulse: stop bit sampled 0
- busy  output  1  high while a frame is in progress

## Operation
- **Reset values.** `parallel_data`=0, `data_valid`=0, `parity_error`=0, `stop_error`=0, `busy`=0, FSM=IDLE, all counters 0.
- **Synchronizer.** `serial_in` passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized value `rx`.
- **Configuration capture.** `prescale`, `parity_enable` and `parity_type` are registered on IDLE->START. Changes during a frame are ignored.
- **Edge counter.** `edge_cnt` counts 0..prescale-1 within each bit and wraps. `bit_cnt` counts data bits 0..DATA_WIDTH-1.
- **Sampling.** `rx` is sampled at `edge_cnt` = prescale/2-1, prescale/2 and prescale/2+1. The bit value is the 2-of-3 majority, decided at `edge_cnt` = prescale/2+1 (the decision point).
- **States:**
  - IDLE: `rx`==0 -> START, with `edge_cnt`=0 in the first START cycle.
  - START: at the decision point, majority 1 -> IDLE (glitch: no outputs, no flags). At `edge_cnt`=prescale-1 -> DATA.
  - DATA: at each decision point, the bit is shifted into the shift register LSB first (data index 0 first). After bit DATA_WIDTH-1 completes (`edge_cnt`=prescale-1) -> PARITY if parity is enabled, else STOP.
  - PARITY: the decision-point bit is stored. At `edge_cnt`=prescale-1 -> STOP.
  - STOP: at the decision point -> IDLE and evaluate the frame. STOP does not wait for the end of the stop bit, which tolerates clock mismatch and allows back-to-back frames.
- **Frame evaluation (registered, visible in the cycle after the STOP decision point):**
  - `stop_error` = ~stop_bit.
  - `parity_error` = parity_en & (received parity bit != XOR(data) ^ parity_type).
  - `data_valid` = ~stop_error & ~parity_error. When `data_valid` is 1, `parallel_data` is loaded in the same cycle. Otherwise `parallel_data` holds its previous value.
  - Both error flags may pulse in the same cycle.
- **busy.** `busy` = (state != IDLE).

## Timing
- Let S be the first START cycle. S follows the first `serial_in` low sample by 2 synchronizer cycles plus 1 FSM cycle.
- Bit k (start = 0) occupies cycles S+k·prescale .. S+(k+1)·prescale-1.
- Let N = 1 + DATA_WIDTH + parity_en. N is the index of the stop bit.
- Output pulse cycle: S + N·prescale + prescale/2 + 2. `busy` is already 0 in that cycle.
- Pulses are exactly one cycle wide.
- Back-to-back frames: the FSM is in IDLE at least prescale/2-2 cycles before the nominal end of the stop bit. A start edge right at the end of the stop bit is therefore detected.
- Reset asserted mid-frame: all outputs return to reset values immediately and no pulse is emitted. After release the FSM starts in IDLE and waits for a new falling edge. A line already low at release is treated as a start.
- A low line held across IDLE (break) re-triggers START. Each resulting frame fails with `stop_error`.

## Test plan
- prescale=8, no parity, frame 0xA5 -> `data_valid` pulse at S+9·8+6 = S+78, `parallel_data`=0xA5, no error flags.
- prescale=16, even parity, 0x3C with parity bit 0 -> `data_valid`, `parallel_data`=0x3C. Repeat with odd parity and parity bit 1 -> valid.
- Even parity, 0x3C with parity bit 1 -> `parity_error` one-cycle pulse, `data_valid`=0, `parallel_data` keeps its previous value.
- Frame 0x81 with stop bit 0 -> `stop_error` pulse, no `data_valid`. Also: stop bit 0 plus a wrong parity bit -> both flags pulse in the same cycle.
- Glitch low for 2 cycles (prescale=8) -> `busy` rises then falls within 8 cycles, no pulses. Then send 0x55 and 0xAA back-to-back with no idle gap -> two `data_valid` pulses, data 0x55 then 0xAA.
- Assert reset during DATA bit 4 of a frame -> outputs 0 immediately, no pulse. After release, the next frame 0x0F is received correctly.
